// File: rtl/conv3x3_rgb888_mac.sv
// ---------------------------------------------------------------------------
// conv3x3_rgb888_mac
//
// Purpose:
//   Consumes one 3x3 window of RGB888 pixels and convolves it with a signed
//   3x3 kernel. One tap is processed per cycle, with R, G and B handled in
//   parallel. Each channel is rounded, arithmetically shifted right by SHIFT,
//   optionally biased, clamped to 0..255 and emitted as one RGB888 pixel.
//   oBusy tells the upstream window stage that a window is in flight.
//
// Optional feature:
//   CONV_BIAS_EN - when defined, adds the iBias port. It carries three signed
//   8-bit per-channel biases in R/G/B byte order. They are latched at accept
//   and added after the shift, before the clamp. When the macro is undefined
//   the bias is zero.
//
// Ports:
//   iClk          in   1   clock
//   iRst          in   1   synchronous reset, active low
//   iValid        in   1   window valid
//   iIn0..iIn8    in   24  window taps, row-major (0 = top-left, 4 = centre)
//   iKernel       in   72  coefficient k at [8k+7:8k], signed
//   iBias         in   24  (CONV_BIAS_EN only) signed per-channel biases
//   oBusy         out  1   high while a window is in flight
//   oPixel        out  24  convolved RGB888 result
//   oValid        out  1   oPixel valid; held until iReady
//   iReady        in   1   downstream accepts when oValid && iReady
// ---------------------------------------------------------------------------
module conv3x3_rgb888_mac #(
   parameter int DATA_W = 24,
   parameter int COEF_W = 8,
   parameter int SHIFT  = 4
) (
   input  logic                iClk,
   input  logic                iRst,
   input  logic                iValid,
   input  logic [DATA_W-1:0]   iIn0,
   input  logic [DATA_W-1:0]   iIn1,
   input  logic [DATA_W-1:0]   iIn2,
   input  logic [DATA_W-1:0]   iIn3,
   input  logic [DATA_W-1:0]   iIn4,
   input  logic [DATA_W-1:0]   iIn5,
   input  logic [DATA_W-1:0]   iIn6,
   input  logic [DATA_W-1:0]   iIn7,
   input  logic [DATA_W-1:0]   iIn8,
   input  logic [9*COEF_W-1:0] iKernel,
`ifdef CONV_BIAS_EN
   input  logic [23:0]         iBias,
`endif
   output logic                oBusy,
   output logic [DATA_W-1:0]   oPixel,
   output logic                oValid,
   input  logic                iReady
);

   // A 9-bit signed pixel times a signed coefficient gives the product width.
   // Nine products add at most 4 bits of growth, so the accumulator cannot
   // overflow. One extra bit leaves headroom for the rounding constant.
   localparam int PROD_W = COEF_W + 9;
   localparam int ACC_W  = PROD_W + 4;
   localparam int SUM_W  = ACC_W + 1;
   localparam logic signed [SUM_W-1:0] ROUND = SUM_W'(1 << (SHIFT - 1));

   typedef enum logic [1:0] {S_IDLE, S_MAC, S_SAT, S_OUT} state_t;

   state_t                   r_state;
   state_t                   w_state_next;
   logic [3:0]               r_tap;
   logic [DATA_W-1:0]        r_win  [0:8];
   logic signed [COEF_W-1:0] r_coef [0:8];
   logic [DATA_W-1:0]        w_in   [0:8];
   logic [DATA_W-1:0]        w_tap_pix;
   logic signed [COEF_W-1:0] w_tap_coef;
   logic [23:0]              w_sat;
   logic [23:0]              w_bias;
   logic                     w_accept;
   logic                     r_busy;
   logic                     r_valid;
   logic [DATA_W-1:0]        r_pixel;

   assign w_in[0] = iIn0;
   assign w_in[1] = iIn1;
   assign w_in[2] = iIn2;
   assign w_in[3] = iIn3;
   assign w_in[4] = iIn4;
   assign w_in[5] = iIn5;
   assign w_in[6] = iIn6;
   assign w_in[7] = iIn7;
   assign w_in[8] = iIn8;

   assign w_accept = (r_state == S_IDLE) && iValid;

   // ---------------- FSM ----------------
   always_ff @(posedge iClk) begin
      if (!iRst) r_state <= S_IDLE;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (iValid)         w_state_next = S_MAC;
         S_MAC:   if (r_tap == 4'd8)  w_state_next = S_SAT;
         S_SAT:                       w_state_next = S_OUT;
         S_OUT:   if (iReady)         w_state_next = S_IDLE;
         default:                     w_state_next = S_IDLE;
      endcase
   end

   // ---------------- window / kernel capture ----------------
   // Taps and coefficients are frozen at accept, so upstream may move on.
   always_ff @(posedge iClk) begin
      if (!iRst) begin
         for (int i = 0; i < 9; i++) begin
            r_win[i]  <= '0;
            r_coef[i] <= '0;
         end
      end else if (w_accept) begin
         for (int i = 0; i < 9; i++) begin
            r_win[i]  <= w_in[i];
            r_coef[i] <= iKernel[COEF_W*i +: COEF_W];
         end
      end
   end

`ifdef CONV_BIAS_EN
   logic [23:0] r_bias;
   always_ff @(posedge iClk) begin
      if (!iRst)         r_bias <= '0;
      else if (w_accept) r_bias <= iBias;
   end
   assign w_bias = r_bias;
`else
   assign w_bias = '0;
`endif

   // Current tap select; the guard keeps the index inside the 9-entry arrays.
   always_comb begin
      w_tap_pix  = '0;
      w_tap_coef = '0;
      if (r_tap <= 4'd8) begin
         w_tap_pix  = r_win[r_tap];
         w_tap_coef = r_coef[r_tap];
      end
   end

   // ---------------- per-channel MAC and saturation ----------------
   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_ch
         logic signed [PROD_W-1:0] w_pix_x;
         logic signed [PROD_W-1:0] w_coef_x;
         logic signed [PROD_W-1:0] w_prod;
         logic signed [ACC_W-1:0]  r_acc;
         logic signed [SUM_W-1:0]  w_rnd;
         logic signed [SUM_W-1:0]  w_shf;
         logic signed [SUM_W-1:0]  w_sum;
         logic signed [7:0]        w_b;
         logic [7:0]               w_clamp;

         // The pixel is unsigned, so a zero MSB is prepended before the
         // signed multiply.
         assign w_pix_x  = PROD_W'($signed({1'b0, w_tap_pix[8*gi +: 8]}));
         assign w_coef_x = PROD_W'(w_tap_coef);
         assign w_prod   = w_pix_x * w_coef_x;

         always_ff @(posedge iClk) begin
            if (!iRst)                 r_acc <= '0;
            else if (w_accept)         r_acc <= '0;
            else if (r_state == S_MAC) r_acc <= r_acc + ACC_W'(w_prod);
         end

         // Round half up, then use an arithmetic shift so negative sums stay
         // negative and clamp to zero.
         assign w_rnd = SUM_W'(r_acc) + ROUND;
         assign w_shf = w_rnd >>> SHIFT;
         assign w_b   = w_bias[8*gi +: 8];
         assign w_sum = w_shf + SUM_W'(w_b);

         always_comb begin
            w_clamp = w_sum[7:0];
            if (w_sum[SUM_W-1])          w_clamp = 8'd0;
            else if (|w_sum[SUM_W-2:8])  w_clamp = 8'hFF;
         end

         assign w_sat[8*gi +: 8] = w_clamp;
      end
   endgenerate

   // ---------------- control / output registers ----------------
   // oBusy and oValid are registered copies of the next state. This leaves
   // no combinational path from iValid to oBusy.
   always_ff @(posedge iClk) begin
      if (!iRst) begin
         r_busy  <= 1'b0;
         r_valid <= 1'b0;
         r_pixel <= '0;
         r_tap   <= '0;
      end else begin
         r_busy  <= (w_state_next != S_IDLE);
         r_valid <= (w_state_next == S_OUT);
         if (w_accept)              r_tap <= '0;
         else if (r_state == S_MAC) r_tap <= r_tap + 4'd1;
         if (r_state == S_SAT)      r_pixel <= DATA_W'(w_sat);
      end
   end

   assign oBusy  = r_busy;
   assign oValid = r_valid;
   assign oPixel = r_pixel;

endmodule
